// File: rtl/priority_encoder_4to2_pkg.sv
// ---------------------------------------------------------------------------
// prior_enco_pkg
// Shared constants and the priority-index helper for the 4-to-2 priority
// encoder. Imported by the interface, the combinational core and the top.
//   IN_W      : number of request inputs (fixed at 4)
//   OUT_W     : encoded index width, $clog2(IN_W)
//   IDLE_CODE : index reported when no request is present
//   prio_idx  : index of the most-significant set bit (bit 3 wins)
// ---------------------------------------------------------------------------
package prior_enco_pkg;

    localparam int IN_W  = 4;
    localparam int OUT_W = 2;

    localparam logic [OUT_W-1:0] IDLE_CODE = 2'b00;

    // Highest-numbered set bit wins; an empty vector falls through to
    // IDLE_CODE, which aliases "bit 0 wins" -- the any/valid flag separates them.
    function automatic logic [OUT_W-1:0] prio_idx(input logic [IN_W-1:0] d);
        logic [OUT_W-1:0] idx;
        if (d[3])      idx = 2'b11;
        else if (d[2]) idx = 2'b10;
        else if (d[1]) idx = 2'b01;
        else           idx = IDLE_CODE;
        return idx;
    endfunction

endpackage

// File: rtl/priority_encoder_4to2_if.sv
// ---------------------------------------------------------------------------
// priority_encoder_4to2_if
// Bundles the request vector and the registered results of the encoder.
//   input_data : request vector, bit 3 highest priority (driven by master)
//   out        : registered winning index              (driven by slave)
//   valid      : registered "any request" flag         (driven by slave)
//   multi      : registered ">1 request" flag, present only when
//                PRIOR_ENCO_MULTI_EN is defined
// Modports: master = request source / result consumer, slave = encoder.
// ---------------------------------------------------------------------------
import prior_enco_pkg::*;

interface priority_encoder_4to2_if;

    logic [IN_W-1:0]  input_data;
    logic [OUT_W-1:0] out;
    logic             valid;
`ifdef PRIOR_ENCO_MULTI_EN
    logic             multi;

    modport master (output input_data, input out, input valid, input multi);
    modport slave  (input input_data, output out, output valid, output multi);
`else
    modport master (output input_data, input out, input valid);
    modport slave  (input input_data, output out, output valid);
`endif

endinterface

// File: rtl/priority_encoder_4to2_comb.sv
// ---------------------------------------------------------------------------
// prior_enco_comb
// Purely combinational core of the priority encoder.
//   i_data  : request vector
//   o_idx   : index of the most-significant set bit (IDLE_CODE when empty)
//   o_any   : at least one request bit set
//   o_multi : two or more request bits set (only with PRIOR_ENCO_MULTI_EN)
// ---------------------------------------------------------------------------
import prior_enco_pkg::*;

module prior_enco_comb (
    input  logic [IN_W-1:0]  i_data,
    output logic [OUT_W-1:0] o_idx,
    output logic             o_any
`ifdef PRIOR_ENCO_MULTI_EN
    ,
    output logic             o_multi
`endif
);

    assign o_idx = prio_idx(i_data);
    assign o_any = |i_data;

`ifdef PRIOR_ENCO_MULTI_EN
    // Bit gi is "also set" when it is set and any lower bit is set too;
    // any such bit means at least two requests are present.
    logic [IN_W-1:0] w_also;

    assign w_also[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < IN_W; gi++) begin : g_also
            assign w_also[gi] = i_data[gi] & (|i_data[gi-1:0]);
        end
    endgenerate

    assign o_multi = |w_also;
`endif

endmodule

// File: rtl/priority_encoder_4to2.sv
// ---------------------------------------------------------------------------
// priority_encoder_4to2
// 4-input priority encoder with a one-cycle registered output.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low clear of all outputs
//   bus   : priority_encoder_4to2_if.slave
//           input_data in; out / valid (/ multi) out, all registered
// Optional feature: define PRIOR_ENCO_MULTI_EN to add the registered multi
// flag (two or more requests present).
// ---------------------------------------------------------------------------
import prior_enco_pkg::*;

module priority_encoder_4to2 (
    input  logic                    clk,
    input  logic                    rst_n,
    priority_encoder_4to2_if.slave  bus
);

    logic [OUT_W-1:0] w_idx;
    logic             w_any;
    logic [OUT_W-1:0] r_out;
    logic             r_valid;

`ifdef PRIOR_ENCO_MULTI_EN
    logic w_multi;
    logic r_multi;

    prior_enco_comb u_comb (
        .i_data  (bus.input_data),
        .o_idx   (w_idx),
        .o_any   (w_any),
        .o_multi (w_multi)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_multi <= 1'b0;
        else        r_multi <= w_multi;
    end

    assign bus.multi = r_multi;
`else
    prior_enco_comb u_comb (
        .i_data (bus.input_data),
        .o_idx  (w_idx),
        .o_any  (w_any)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out   <= IDLE_CODE;
            r_valid <= 1'b0;
        end else begin
            r_out   <= w_idx;
            r_valid <= w_any;
        end
    end

    assign bus.out   = r_out;
    assign bus.valid = r_valid;

endmodule

// File: tb/tb_priority_encoder_4to2.sv
// ---------------------------------------------------------------------------
// tb_priority_encoder_4to2
// Self-checking bench: a reference model of the registered encoder, a
// negedge compare process, directed literal checks and random stimulus.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_priority_encoder_4to2;

    logic clk;
    logic rst_n;

    priority_encoder_4to2_if bus ();

    priority_encoder_4to2 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Reference: position of the highest set bit, found by scanning upward.
    function automatic int ref_idx(input logic [3:0] d);
        int r = 0;
        for (int i = 0; i < 4; i++) if (d[i]) r = i;
        return r;
    endfunction

    // Model of what the registered outputs must hold.
    logic [1:0] exp_out   = 2'b00;
    logic       exp_valid = 1'b0;
    logic       exp_multi = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_out   <= 2'b00;
            exp_valid <= 1'b0;
            exp_multi <= 1'b0;
        end else begin
            exp_out   <= 2'(ref_idx(bus.input_data));
            exp_valid <= (bus.input_data != 4'd0);
            exp_multi <= ($countones(bus.input_data) >= 2);
        end
    end

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Continuous compare against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_out",   int'(bus.out),   int'(exp_out));
            check("model_valid", int'(bus.valid), int'(exp_valid));
`ifdef PRIOR_ENCO_MULTI_EN
            check("model_multi", int'(bus.multi), int'(exp_multi));
`endif
            $display("cyc t=%0t in=%b rst_n=%b out=%b valid=%b", $time,
                     bus.input_data, rst_n, bus.out, bus.valid);
        end
    end

    // Drive one vector and check the result one edge later against literals.
    task automatic apply(input logic [3:0] v, input logic [1:0] eo,
                         input logic ev, input logic em);
        @(negedge clk);
        bus.input_data = v;
        @(posedge clk);
        #1;
        check("lit_out",   int'(bus.out),   int'(eo));
        check("lit_valid", int'(bus.valid), int'(ev));
`ifdef PRIOR_ENCO_MULTI_EN
        check("lit_multi", int'(bus.multi), int'(em));
`else
        if (em === 1'bx) $display("unused multi expectation");
`endif
    endtask

    initial begin
        // 1: hold reset with all requests set
        rst_n = 1'b0;
        bus.input_data = 4'b1111;
        @(negedge clk);
        chk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_out",   int'(bus.out),   0);
            check("rst_valid", int'(bus.valid), 0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_out",   int'(bus.out),   3);
        check("post_rst_valid", int'(bus.valid), 1);

        // 2,3: empty and single requests
        apply(4'b0000, 2'b00, 1'b0, 1'b0);
        apply(4'b0001, 2'b00, 1'b1, 1'b0);
        apply(4'b0100, 2'b10, 1'b1, 1'b0);
        apply(4'b0101, 2'b10, 1'b1, 1'b1);
        apply(4'b0011, 2'b01, 1'b1, 1'b1);
        apply(4'b1100, 2'b11, 1'b1, 1'b1);
        apply(4'b1111, 2'b11, 1'b1, 1'b1);

        // 4: sweep all 16 values (checked by the compare process)
        for (int v = 0; v < 16; v++) begin
            @(negedge clk);
            bus.input_data = 4'(v);
        end

        // 5: asynchronous reset between edges
        apply(4'b1000, 2'b11, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_out",   int'(bus.out),   0);
        check("async_valid", int'(bus.valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(4'b0110, 2'b10, 1'b1, 1'b1);

        // 6: back-to-back sequence
        apply(4'b0010, 2'b01, 1'b1, 1'b0);
        apply(4'b1001, 2'b11, 1'b1, 1'b1);
        apply(4'b0000, 2'b00, 1'b0, 1'b0);

        // Random stimulus with occasional mid-cycle reset pulses
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            bus.input_data = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) begin
                #2;
                rst_n = 1'b0;
                #2;
                rst_n = 1'b1;
            end
        end

        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
